// File: rtl/pwm_compare_deadtime.sv
// rtl/pwm_compare_deadtime.sv - carrier compare with complementary gate pair and dead-time insertion
module pwm_compare_deadtime #(
  parameter int CNT_WIDTH = 16,
  parameter int DT_WIDTH  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_onoff,
  input  logic [CNT_WIDTH-1:0] carrier,
  input  logic                 maskevent,
  input  logic [CNT_WIDTH-1:0] compare,
  input  logic [DT_WIDTH-1:0]  deadtime,
  output logic                 pwm_h,
  output logic                 pwm_l,
  output logic                 dt_busy
);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_LOW   = 3'd1,
    ST_DT_LH = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DT_HL = 3'd4
  } state_t;

  localparam logic [DT_WIDTH-1:0] DT_ZERO = '0;
  localparam logic [DT_WIDTH-1:0] DT_ONE  = DT_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_compare_act;
  logic [DT_WIDTH-1:0]   r_deadtime_act;
  logic [DT_WIDTH-1:0]   r_counter;
  logic [DT_WIDTH-1:0]   w_counter_nxt;
  logic                  r_ref_q;
  logic                  w_shadow_load;

  // While the leg is disabled the shadow tracks the inputs, so a freshly
  // enabled leg starts with the current software values.
  assign w_shadow_load = maskevent | ~pwm_onoff;

  // Shadow registers: only updated at the carrier mask point or while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_compare_act  <= '0;
      r_deadtime_act <= '0;
    end else if (w_shadow_load) begin
      r_compare_act  <= compare;
      r_deadtime_act <= deadtime;
    end
  end

  // Modulating reference; uses the compare value active before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref_q <= 1'b0;
    end else begin
      r_ref_q <= pwm_onoff & (carrier < r_compare_act);
    end
  end

  // State and dead-time counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_OFF;
      r_counter <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_counter <= w_counter_nxt;
    end
  end

  // Next-state logic; disabling the leg overrides everything, even mid dead time.
  always_comb begin
    w_state_nxt   = r_state;
    w_counter_nxt = r_counter;
    if (!pwm_onoff) begin
      w_state_nxt   = ST_OFF;
      w_counter_nxt = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_LOW;
        end
        ST_LOW: begin
          if (r_ref_q) begin
            if (r_deadtime_act == DT_ZERO) begin
              w_state_nxt = ST_HIGH;
            end else begin
              w_state_nxt   = ST_DT_LH;
              w_counter_nxt = r_deadtime_act;
            end
          end
        end
        ST_DT_LH: begin
          if (!r_ref_q) begin
            w_state_nxt = ST_LOW;
          end else if (r_counter == DT_ONE) begin
            w_state_nxt = ST_HIGH;
          end else begin
            w_counter_nxt = r_counter - DT_ONE;
          end
        end
        ST_HIGH: begin
          if (!r_ref_q) begin
            if (r_deadtime_act == DT_ZERO) begin
              w_state_nxt = ST_LOW;
            end else begin
              w_state_nxt   = ST_DT_HL;
              w_counter_nxt = r_deadtime_act;
            end
          end
        end
        ST_DT_HL: begin
          if (r_ref_q) begin
            w_state_nxt = ST_HIGH;
          end else if (r_counter == DT_ONE) begin
            w_state_nxt = ST_LOW;
          end else begin
            w_counter_nxt = r_counter - DT_ONE;
          end
        end
        default: begin
          w_state_nxt   = ST_OFF;
          w_counter_nxt = '0;
        end
      endcase
    end
  end

  assign pwm_h   = (r_state == ST_HIGH);
  assign pwm_l   = (r_state == ST_LOW);
  assign dt_busy = (r_state == ST_DT_LH) || (r_state == ST_DT_HL);

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// tb/tb_pwm_compare_deadtime.sv - scoreboard bench for pwm_compare_deadtime
module tb_pwm_compare_deadtime;

  logic        clk;
  logic        reset;
  logic        pwm_onoff;
  logic [15:0] carrier;
  logic        maskevent;
  logic [15:0] compare;
  logic [9:0]  deadtime;
  logic        pwm_h;
  logic        pwm_l;
  logic        dt_busy;

  pwm_compare_deadtime #(.CNT_WIDTH(16), .DT_WIDTH(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_onoff (pwm_onoff),
    .carrier   (carrier),
    .maskevent (maskevent),
    .compare   (compare),
    .deadtime  (deadtime),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l),
    .dt_busy   (dt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cval    = 0;
  logic [2:0] exp_q[$];

  // Reference model: the leg has a committed side (low/high). The reference
  // must hold the opposite value for (dead time + 1) consecutive samples before
  // the side switches; in between both gates are off and the leg is busy.
  bit          m_ref;
  int          m_run;
  logic [15:0] m_cmp;
  int          m_dt;
  int          m_lock;
  bit          m_side;
  bit          m_off;

  task automatic model_edge();
    bit e_h, e_l, e_b;
    bit new_ref;
    e_h = 0; e_l = 0; e_b = 0;
    if (reset) begin
      m_ref = 0; m_run = 1; m_cmp = 16'd0; m_dt = 0;
      m_lock = 0; m_side = 0; m_off = 1;
    end else begin
      new_ref = pwm_onoff && (carrier < m_cmp);
      if (!pwm_onoff) begin
        m_side = 0;
        m_off  = 1;
      end else if (m_off) begin
        e_l    = 1;
        m_side = 0;
        m_off  = 0;
      end else if (m_ref == m_side) begin
        e_h = m_side;
        e_l = !m_side;
      end else begin
        if (m_run == 1) m_lock = m_dt;
        if (m_run >= m_lock + 1) begin
          m_side = m_ref;
          e_h = m_side;
          e_l = !m_side;
        end else begin
          e_b = 1;
        end
      end
      if (maskevent || !pwm_onoff) begin
        m_cmp = compare;
        m_dt  = int'(deadtime);
      end
      m_run = (new_ref == m_ref) ? m_run + 1 : 1;
      m_ref = new_ref;
    end
    exp_q.push_back({e_h, e_l, e_b});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_carrier(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      carrier   = 16'(cval);
      maskevent = (cval == 0);
      step();
      cval = (cval + 1) % period;
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation away from the edge.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({pwm_h, pwm_l, dt_busy} !== e) begin
          n_fail++;
          $display("FAIL gates t=%0t got h/l/busy=%b required=%b", $time, {pwm_h, pwm_l, dt_busy}, e);
        end
      end
    end
  end

  initial begin
    int period;
    reset = 1; pwm_onoff = 1; carrier = 0; maskevent = 0;
    compare = 16'd100; deadtime = 10'd5;
    m_ref = 0; m_run = 1; m_cmp = 0; m_dt = 0; m_lock = 0; m_side = 0; m_off = 1;

    // Reset held with carrier running, then nominal 100/200 with 5 dead time.
    run_carrier(3, 200);
    reset = 0;
    run_carrier(600, 200);

    // Zero dead time.
    compare = 16'd50; deadtime = 10'd0;
    run_carrier(400, 200);

    // Compare rewrite mid-period takes effect only after the mask event.
    compare = 16'd100; deadtime = 10'd5;
    run_carrier(200, 200);
    run_carrier(50, 200);
    compare = 16'd150;
    run_carrier(350, 200);

    // Short reference pulse swallowed by a long dead time.
    compare = 16'd3; deadtime = 10'd8;
    run_carrier(400, 200);

    // Disable while in the high-to-low dead time.
    compare = 16'd100; deadtime = 10'd8;
    run_carrier(200 - cval, 200);
    run_carrier(200, 200);
    run_carrier(105, 200);
    pwm_onoff = 0;
    run_carrier(3, 200);
    pwm_onoff = 1;
    run_carrier(295, 200);

    // Compare extremes.
    compare = 16'd0; deadtime = 10'd5;
    run_carrier(400, 200);
    compare = 16'hFFFF;
    run_carrier(400, 200);

    // Randomized periods, values, disables, resets and stray writes.
    for (int p = 0; p < 40; p++) begin
      period = int'($urandom_range(20, 300));
      cval = 0;
      case ($urandom_range(0, 5))
        0:       compare = 16'd0;
        1:       compare = 16'hFFFF;
        default: compare = 16'($urandom_range(0, period + 5));
      endcase
      deadtime = 10'($urandom_range(0, 15));
      for (int i = 0; i < period; i++) begin
        if ($urandom_range(0, 49) == 0) compare = 16'($urandom_range(0, period));
        if ($urandom_range(0, 49) == 0) deadtime = 10'($urandom_range(0, 20));
        if ($urandom_range(0, 299) == 0) pwm_onoff = 0;
        else if (!pwm_onoff && $urandom_range(0, 3) == 0) pwm_onoff = 1;
        reset = ($urandom_range(0, 799) == 0);
        carrier   = 16'(cval);
        maskevent = (cval == 0) || ($urandom_range(0, 199) == 0);
        step();
        cval = (cval + 1) % period;
      end
      reset = 0;
      pwm_onoff = 1;
    end

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
